// File: rtl/dii_ring_pkt_arbiter.sv
// Packet-atomic round-robin merge of PORTS DII flit streams onto one registered 16-bit output.
// Over-length packets are cut at MAX_PKT_LEN flits and the rest of the packet is drained.
module dii_ring_pkt_arbiter #(
    parameter int unsigned PORTS       = 2,
    parameter int unsigned MAX_PKT_LEN = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PORTS-1:0]      in_valid,
    input  logic [PORTS-1:0]      in_last,
    input  logic [16*PORTS-1:0]   in_data,
    output logic [PORTS-1:0]      in_ready,
    output logic                  out_valid,
    output logic                  out_last,
    output logic [15:0]           out_data,
    input  logic                  out_ready,
    output logic [PORTS-1:0]      grant,
    output logic                  err_overlen
);

    localparam int unsigned IdxW = $clog2(PORTS);
    localparam int unsigned CntW = $clog2(MAX_PKT_LEN + 1);

    typedef enum logic [1:0] {StIdle, StFwd, StDrop} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   g_q, g_d;
    logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [15:0]       out_data_q, out_data_d;

    logic              sel_valid, sel_last, fwd_rdy, found;
    logic [15:0]       sel_data;
    logic [IdxW-1:0]   next_ptr, scan_idx;

    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        err_d       = 1'b0;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        in_ready    = '0;
        grant       = '0;
        found       = 1'b0;
        fwd_rdy     = 1'b0;
        scan_idx    = '0;
        sel_valid   = 1'b0;
        sel_last    = 1'b0;
        sel_data    = '0;

        for (int i = 0; i < int'(PORTS); i++) begin
            if (g_q == IdxW'(i)) begin
                sel_valid = in_valid[i];
                sel_last  = in_last[i];
                sel_data  = in_data[16*i +: 16];
            end
        end
        next_ptr = (g_q == IdxW'(PORTS - 1)) ? '0 : g_q + IdxW'(1);

        // Drain first; a load below overrides it for full throughput.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = '0;
        end

        unique case (state_q)
            StIdle: begin
                for (int k = 0; k < int'(PORTS); k++) begin
                    scan_idx = IdxW'((int'(rr_ptr_q) + k) % int'(PORTS));
                    if (!found && in_valid[scan_idx]) begin
                        found = 1'b1;
                        g_d   = scan_idx;
                    end
                end
                if (found) begin
                    cnt_d   = '0;
                    state_d = StFwd;
                end
            end
            StFwd: begin
                fwd_rdy       = !out_valid_q || out_ready;
                in_ready[g_q] = fwd_rdy;
                grant[g_q]    = 1'b1;
                if (sel_valid && fwd_rdy) begin
                    out_valid_d = 1'b1;
                    out_data_d  = sel_data;
                    out_last_d  = sel_last;
                    cnt_d       = cnt_q + CntW'(1);
                    if (sel_last) begin
                        state_d  = StIdle;
                        rr_ptr_d = next_ptr;
                    end else if (cnt_q == CntW'(MAX_PKT_LEN - 1)) begin
                        out_last_d = 1'b1;
                        err_d      = 1'b1;
                        state_d    = StDrop;
                    end
                end
            end
            StDrop: begin
                in_ready[g_q] = 1'b1;
                grant[g_q]    = 1'b1;
                if (sel_valid && sel_last) begin
                    state_d  = StIdle;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            g_q         <= '0;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign out_data    = out_data_q;
    assign err_overlen = err_q;

endmodule

// File: tb/tb_dii_ring_pkt_arbiter.sv
// Self-checking bench for dii_ring_pkt_arbiter: packet table, fairness, backpressure, reset cases.
module tb_dii_ring_pkt_arbiter;

    localparam int MAX = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  in_valid, in_last, in_ready, grant;
    logic [31:0] in_data;
    logic        out_valid, out_last, out_ready, err_overlen;
    logic [15:0] out_data;

    logic        tb_valid [2];
    logic        tb_last  [2];
    logic [15:0] tb_data  [2];

    assign in_valid = {tb_valid[1], tb_valid[0]};
    assign in_last  = {tb_last[1], tb_last[0]};
    assign in_data  = {tb_data[1], tb_data[0]};

    always #5 clk = ~clk;

    dii_ring_pkt_arbiter #(.PORTS(2), .MAX_PKT_LEN(MAX)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .grant       (grant),
        .err_overlen (err_overlen)
    );

    typedef struct {
        int          port;
        int          len;
        logic [15:0] base;
        int          exp_out;
        int          exp_err;
        logic [1:0]  exp_grant;
    } vec_t;

    logic [16:0] exp_q [$];
    int          xfer_cyc [$];
    int          checks, errors, out_cnt, err_cnt, acc_cnt, cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Output monitor: every output transfer is checked against the scoreboard.
    initial begin
        logic [16:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (err_overlen) err_cnt++;
                if (out_valid && out_ready) begin
                    out_cnt++;
                    xfer_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL out_unexpected actual=%h/%b required=none", out_data, out_last);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_flit", {15'b0, out_data, out_last}, {15'b0, e});
                    end
                end
            end
        end
    end

    task automatic send_flit(input int p, input logic [15:0] d, input logic last,
                             input bit push, input logic [1:0] eg, input bit trunc,
                             output bit ok);
        int n;
        ok = 1'b1;
        n = 0;
        tb_valid[p] = 1'b1;
        tb_last[p]  = last;
        tb_data[p]  = d;
        forever begin
            @(negedge clk);
            if (in_ready[p]) break;
            n++;
            if (n > 300) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout port=%0d actual=no_ready required=ready", p);
                tb_valid[p] = 1'b0;
                ok = 1'b0;
                return;
            end
        end
        chk("grant_on_accept", {30'b0, grant}, {30'b0, eg});
        if (push) exp_q.push_back({d, last | trunc});
        @(posedge clk);
        #1;
        acc_cnt++;
    endtask

    task automatic send_pkt(input int p, input int len, input logic [15:0] base,
                            input bit push, input logic [1:0] eg);
        bit          ok;
        logic [15:0] d;
        for (int i = 0; i < len; i++) begin
            d = 16'(base * (i + 1));
            send_flit(p, d, (i == len - 1), push && (i < MAX), eg, (i == MAX - 1), ok);
            if (!ok) break;
        end
        tb_valid[p] = 1'b0;
        tb_last[p]  = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"}, {30'b0, in_ready}, 32'h0);
        chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'h0);
        chk({tag, "_out_last"}, {31'b0, out_last}, 32'h0);
        chk({tag, "_out_data"}, {16'b0, out_data}, 32'h0);
        chk({tag, "_grant"}, {30'b0, grant}, 32'h0);
        chk({tag, "_err"}, {31'b0, err_overlen}, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [5];
        int          o0, e0, a0, n;
        bit          ok;
        logic [15:0] saved;

        checks = 0; errors = 0; out_cnt = 0; err_cnt = 0; acc_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            tb_valid[i] = 1'b0;
            tb_last[i]  = 1'b0;
            tb_data[i]  = '0;
        end
        out_ready = 1'b1;

        vecs[0] = '{port: 0, len: 3,  base: 16'h1111, exp_out: 3,  exp_err: 0, exp_grant: 2'b01};
        vecs[1] = '{port: 0, len: 16, base: 16'h0203, exp_out: 16, exp_err: 0, exp_grant: 2'b01};
        vecs[2] = '{port: 1, len: 1,  base: 16'h00AA, exp_out: 1,  exp_err: 0, exp_grant: 2'b10};
        vecs[3] = '{port: 0, len: 17, base: 16'h0305, exp_out: 16, exp_err: 1, exp_grant: 2'b01};
        vecs[4] = '{port: 1, len: 20, base: 16'h0101, exp_out: 16, exp_err: 1, exp_grant: 2'b10};

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[v]) begin
            o0 = out_cnt;
            e0 = err_cnt;
            send_pkt(vecs[v].port, vecs[v].len, vecs[v].base, 1'b1, vecs[v].exp_grant);
            drain();
            chk("vec_out_count", out_cnt - o0, vecs[v].exp_out);
            chk("vec_err_pulses", err_cnt - e0, vecs[v].exp_err);
            chk("vec_grant_idle", {30'b0, grant}, 32'h0);
            chk("vec_scoreboard_empty", exp_q.size(), 0);
        end

        // Last vector was a truncated port-1 packet, so port 0 must win next.
        exp_q.push_back({16'h5555, 1'b1});
        exp_q.push_back({16'h6666, 1'b1});
        fork
            send_pkt(0, 1, 16'h5555, 1'b0, 2'b01);
            send_pkt(1, 1, 16'h6666, 1'b0, 2'b10);
        join
        drain();
        chk("rr_after_drop_empty", exp_q.size(), 0);

        // Backpressure mid-packet.
        o0 = out_cnt;
        fork
            send_pkt(0, 6, 16'h0707, 1'b1, 2'b01);
            begin
                n = 0;
                while (out_cnt < o0 + 2 && n < 300) begin
                    @(posedge clk);
                    n++;
                end
                chk("bp_reach_mid", {31'b0, n < 300}, 32'h1);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                saved = out_data;
                a0 = acc_cnt;
                chk("bp_valid_start", {31'b0, out_valid}, 32'h1);
                repeat (4) begin
                    @(negedge clk);
                    chk("bp_valid_hold", {31'b0, out_valid}, 32'h1);
                    chk("bp_data_hold", {16'b0, out_data}, {16'b0, saved});
                end
                @(posedge clk);
                #1;
                chk("bp_absorbed_le1", {31'b0, (acc_cnt - a0) <= 1}, 32'h1);
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_out_count", out_cnt - o0, 6);
        chk("bp_scoreboard_empty", exp_q.size(), 0);

        // Reset after 2 of 4 flits.
        send_flit(0, 16'hC001, 1'b0, 1'b1, 2'b01, 1'b0, ok);
        send_flit(0, 16'hC002, 1'b0, 1'b1, 2'b01, 1'b0, ok);
        tb_data[0] = 16'hC003;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("midrst");
        tb_valid[0] = 1'b0;
        rst = 1'b0;
        exp_q.delete();
        o0 = out_cnt;
        send_pkt(1, 2, 16'h0E0E, 1'b1, 2'b10);
        drain();
        chk("midrst_out_count", out_cnt - o0, 2);
        chk("midrst_scoreboard_empty", exp_q.size(), 0);

        // Fairness from reset: expected order 0,1,0,1 queued up front.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        xfer_cyc.delete();
        exp_q.push_back({16'h1000, 1'b0});
        exp_q.push_back({16'h2000, 1'b1});
        exp_q.push_back({16'h0100, 1'b0});
        exp_q.push_back({16'h0200, 1'b1});
        exp_q.push_back({16'h0010, 1'b0});
        exp_q.push_back({16'h0020, 1'b1});
        exp_q.push_back({16'h0001, 1'b0});
        exp_q.push_back({16'h0002, 1'b1});
        fork
            begin
                send_pkt(0, 2, 16'h1000, 1'b0, 2'b01);
                send_pkt(0, 2, 16'h0010, 1'b0, 2'b01);
            end
            begin
                send_pkt(1, 2, 16'h0100, 1'b0, 2'b10);
                send_pkt(1, 2, 16'h0001, 1'b0, 2'b10);
            end
        join
        drain();
        chk("fair_scoreboard_empty", exp_q.size(), 0);
        chk("fair_xfer_count", xfer_cyc.size(), 8);
        if (xfer_cyc.size() == 8) begin
            chk("fair_in_pkt_gap", xfer_cyc[1] - xfer_cyc[0], 1);
            for (int k = 1; k < 4; k++) begin
                chk("fair_pkt_gap", xfer_cyc[2*k] - xfer_cyc[2*k-1], 2);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
